// File: rtl/edge_pack_if.sv
// Handshake bundle between edge_pack, the upstream sobel FIFO and the downstream packed FIFO.
// The master modport is the edge_pack side.
interface edge_pack_if #(
    parameter int DWIDTH_IN  = 8,
    parameter int PACK_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
);
    logic                  in_rd_en;
    logic [DWIDTH_IN-1:0]  in_dout;
    logic                  in_empty;
    logic                  out_wr_en;
    logic [PACK_WIDTH-1:0] out_din;
    logic                  out_full;
    logic [CNT_WIDTH-1:0]  edge_count;
    logic                  frame_done;

    modport master (
        output in_rd_en, out_wr_en, out_din, edge_count, frame_done,
        input  in_dout, in_empty, out_full
    );

    modport slave (
        input  in_rd_en, out_wr_en, out_din, edge_count, frame_done,
        output in_dout, in_empty, out_full
    );
endinterface

// File: rtl/edge_pack.sv
// Thresholds sobel magnitudes to edge flags, packs them LSB-first into row-aligned words
// and reports the edge-pixel count of every completed frame.
module edge_pack #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH_IN  = 8,
    parameter int PACK_WIDTH = 8,
    parameter int THRESHOLD  = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic        clock,
    input  logic        reset,
    edge_pack_if.master bus
);
    localparam int BW = $clog2(PACK_WIDTH + 1);
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [BW-1:0]        BIT_LAST = BW'(PACK_WIDTH - 1);
    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]        COL_END  = CW'(IMG_WIDTH);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [DWIDTH_IN-1:0] THR      = DWIDTH_IN'(THRESHOLD);

    typedef enum logic {S_ACCUM = 1'b0, S_EMIT = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_bit_cnt;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [CNT_WIDTH-1:0]  r_run_cnt;
    logic [CNT_WIDTH-1:0]  r_edge_count;
    logic [PACK_WIDTH-1:0] r_word;
    logic                  r_frame_done;

    logic w_pop;
    logic w_push;
    logic w_flag;
    logic w_row_end;

    assign w_flag    = (bus.in_dout >= THR);
    // col runs one past the last pixel once a row is fully popped, marking the row's final word
    assign w_row_end = (r_col == COL_END);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_ACCUM;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACCUM: if (w_pop && (r_bit_cnt == BIT_LAST || r_col == COL_LAST)) w_next = S_EMIT;
            S_EMIT:  if (w_push) w_next = S_ACCUM;
            default: w_next = S_ACCUM;
        endcase
    end

    always_comb begin
        w_pop  = 1'b0;
        w_push = 1'b0;
        if (!reset) begin
            w_pop  = (r_state == S_ACCUM) && !bus.in_empty;
            w_push = (r_state == S_EMIT)  && !bus.out_full;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_run_cnt    <= '0;
            r_word       <= '0;
            r_edge_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                for (int i = 0; i < PACK_WIDTH; i++) begin
                    if (r_bit_cnt == BW'(i)) r_word[i] <= w_flag;
                end
                if (w_flag && (r_run_cnt != '1)) r_run_cnt <= r_run_cnt + CNT_WIDTH'(1);
                r_bit_cnt <= r_bit_cnt + BW'(1);
                r_col     <= r_col + CW'(1);
            end
            if (w_push) begin
                r_word    <= '0;
                r_bit_cnt <= '0;
                if (w_row_end) begin
                    r_col <= '0;
                    if (r_row == ROW_LAST) begin
                        r_row        <= '0;
                        r_edge_count <= r_run_cnt;
                        r_run_cnt    <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
            end
        end
    end

    assign bus.in_rd_en   = w_pop;
    assign bus.out_wr_en  = w_push;
    assign bus.out_din    = r_word;
    assign bus.edge_count = r_edge_count;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_edge_pack.sv
// Scoreboard bench for edge_pack: a row-level reference model queues expected words and frame
// counts as pixels are issued, and a negedge monitor checks every write and frame pulse.
module tb_edge_pack;
    localparam int W  = 10;
    localparam int H  = 2;
    localparam int P  = 8;
    localparam int TH = 128;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    edge_pack_if #(.DWIDTH_IN(8), .PACK_WIDTH(P), .CNT_WIDTH(32)) bus ();

    edge_pack #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8),
        .PACK_WIDTH(P), .THRESHOLD(TH), .CNT_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   src_q[$];
    logic [P-1:0] exp_q[$];
    logic [31:0]  cnt_q[$];
    bit           m_row[$];
    int           m_rows  = 0;
    int           m_edges = 0;

    int gap_pct    = 0;
    int full_pct   = 0;
    bit force_full = 1'b0;
    bit rd_seen    = 1'b0;
    int pop_col    = 0;
    bit pend_lat   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: collects a whole row of flags, then cuts it into words.
    task automatic push_pix(input logic [7:0] p);
        src_q.push_back(p);
        m_row.push_back(p >= 8'(TH));
        if (p >= 8'(TH)) m_edges++;
        if (m_row.size() == W) begin
            for (int w = 0; w < (W + P - 1) / P; w++) begin
                logic [P-1:0] wd;
                wd = '0;
                for (int b = 0; b < P; b++)
                    if ((w * P + b) < W && m_row[w * P + b]) wd[b] = 1'b1;
                exp_q.push_back(wd);
            end
            m_row.delete();
            m_rows++;
            if (m_rows == H) begin
                cnt_q.push_back(32'(m_edges));
                m_edges = 0;
                m_rows  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_row.delete();
        m_rows  = 0;
        m_edges = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || cnt_q.size() != 0) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (src_q.size() != 0 || exp_q.size() != 0 || cnt_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=src%0d/exp%0d/cnt%0d required=0/0/0",
                     name, src_q.size(), exp_q.size(), cnt_q.size());
        end
        repeat (2) @(posedge clock);
    endtask

    // Upstream/downstream FIFO behaviour, updated just after each active edge.
    initial begin
        bus.in_empty = 1'b1;
        bus.in_dout  = '0;
        bus.out_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (rd_seen && src_q.size() != 0) void'(src_q.pop_front());
            if (src_q.size() == 0 || int'($urandom_range(99)) < gap_pct) begin
                bus.in_empty = 1'b1;
                bus.in_dout  = 8'($urandom);
            end else begin
                bus.in_empty = 1'b0;
                bus.in_dout  = src_q[0];
            end
            bus.out_full = force_full || (int'($urandom_range(99)) < full_pct);
        end
    end

    // Monitor: the values seen here are what the next active edge acts on.
    always @(negedge clock) begin
        rd_seen = bus.in_rd_en;
        if (reset) begin
            pop_col  = 0;
            pend_lat = 1'b0;
            check("rst_rd_en", 32'(bus.in_rd_en), 32'd0);
            check("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
        end else begin
            if (pend_lat) begin
                check("emit_latency", 32'(bus.out_wr_en), 32'(!bus.out_full));
                check("emit_no_pop", 32'(bus.in_rd_en), 32'd0);
                pend_lat = 1'b0;
            end
            if (bus.in_rd_en) begin
                check("pop_when_empty", 32'(bus.in_empty), 32'd0);
                pend_lat = ((pop_col % P) == P - 1) || (pop_col == W - 1);
                pop_col  = (pop_col == W - 1) ? 0 : pop_col + 1;
            end
            if (bus.out_wr_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%0h required=none", bus.out_din);
                end else begin
                    check("word", 32'(bus.out_din), 32'(exp_q.pop_front()));
                end
            end
            if (bus.frame_done) begin
                if (cnt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_done actual=1 required=0");
                end else begin
                    check("edge_count", bus.edge_count, cnt_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] row0 [W];
        logic [7:0] a5 [P];
        row0 = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd0, 8'd0, 8'd200, 8'd1, 8'd255, 8'd0};
        a5   = '{8'd200, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd200};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_din", 32'(bus.out_din), 32'd0);
        check("rst_edge_count", bus.edge_count, 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Mixed threshold pattern, then a full row of edges
        for (int i = 0; i < W; i++) push_pix(row0[i]);
        for (int i = 0; i < W; i++) push_pix(8'd255);
        drain("directed", 200);

        for (int i = 0; i < W * H; i++) push_pix(8'd255);
        drain("all_edges", 200);

        // Output FIFO held full while the word 0xA5 waits
        force_full = 1'b1;
        for (int i = 0; i < P; i++) push_pix(a5[i]);
        push_pix(8'd255);
        push_pix(8'd0);
        begin
            int n;
            n = 0;
            while (src_q.size() > 2 && n < 100) begin
                @(posedge clock);
                #2;
                n++;
            end
            check("stall_reached", 32'(src_q.size()), 32'd2);
        end
        repeat (5) begin
            @(negedge clock);
            check("stall_wr_en", 32'(bus.out_wr_en), 32'd0);
            check("stall_rd_en", 32'(bus.in_rd_en), 32'd0);
            check("stall_out_din", 32'(bus.out_din), 32'ha5);
        end
        @(posedge clock);
        force_full = 1'b0;
        for (int i = 0; i < W; i++) push_pix(8'($urandom));
        drain("stall", 400);

        // Random FIFO stalls on both sides
        gap_pct  = 40;
        full_pct = 30;
        for (int i = 0; i < 3 * W * H; i++) push_pix(8'((i * 37) & 8'hFF));
        for (int i = 0; i < 2 * W * H; i++) push_pix(8'($urandom));
        drain("random", 2000);
        gap_pct  = 0;
        full_pct = 0;

        // Reset partway through row 1
        for (int i = 0; i < W + 5; i++) push_pix(8'($urandom_range(255, 128)));
        drain("pre_reset", 300);
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < W * H; i++) push_pix(8'((i * 37) & 8'hFF));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_reset_edge_count", bus.edge_count, 32'd0);
        check("post_reset_frame_done", 32'(bus.frame_done), 32'd0);
        drain("post_reset", 300);

        // Back-to-back frames: no edges, then all edges
        for (int i = 0; i < W * H; i++) push_pix(8'd0);
        for (int i = 0; i < W * H; i++) push_pix(8'd255);
        drain("back_to_back", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
